// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Control FSM for a multicycle MIPS-subset datapath
//               (lw, sw, R-type add/sub/and/or/slt, beq, j, addi).
//               Moore outputs decoded from the current state; pcEn also
//               depends on `zero` in BRANCH. Counts retired instructions
//               and pulses `illegal` for unsupported opcodes/functs.
// Ports       : clk, reset (async, active-high)
//               opcode[0:5], funct[0:5], zero         - decode inputs
//               pcEn, IorD, memRead, memWrite, irWrite,
//               regWrite, regDst, memToReg, aluSrcA   - 1-bit controls
//               aluSrcB[0:1], pcSource[0:1]           - mux selects
//               inputULA[0:3]                         - ALU operation
//               illegal                               - 1-cycle pulse
//               retired[0:31]                         - retired count
//               state[0:3]                            - debug state
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [0:5]  opcode,
    input  logic [0:5]  funct,
    input  logic        zero,
    output logic [0:3]  inputULA,
    output logic        pcEn,
    output logic        IorD,
    output logic        memRead,
    output logic        memWrite,
    output logic        irWrite,
    output logic        regWrite,
    output logic        regDst,
    output logic        memToReg,
    output logic        aluSrcA,
    output logic [0:1]  aluSrcB,
    output logic [0:1]  pcSource,
    output logic        illegal,
    output logic [0:31] retired,
    output logic [0:3]  state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXE  = 4'd6,
        S_RTWB   = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [0:5] c_op_rtype = 6'b000000;
    localparam logic [0:5] c_op_lw    = 6'b100011;
    localparam logic [0:5] c_op_sw    = 6'b101011;
    localparam logic [0:5] c_op_beq   = 6'b000100;
    localparam logic [0:5] c_op_j     = 6'b000010;
    localparam logic [0:5] c_op_addi  = 6'b001000;

    localparam logic [0:5] c_fn_add   = 6'b100000;
    localparam logic [0:5] c_fn_sub   = 6'b100010;
    localparam logic [0:5] c_fn_and   = 6'b100100;
    localparam logic [0:5] c_fn_or    = 6'b100101;
    localparam logic [0:5] c_fn_slt   = 6'b101010;

    localparam logic [0:3] c_alu_add  = 4'b0010;
    localparam logic [0:3] c_alu_sub  = 4'b0110;
    localparam logic [0:3] c_alu_and  = 4'b0000;
    localparam logic [0:3] c_alu_or   = 4'b0001;
    localparam logic [0:3] c_alu_slt  = 4'b0111;

    state_t      state_q, state_d;
    logic [31:0] retired_q, retired_d;
    logic        illegal_q, illegal_d;

    // Raw enables before the reset gate.
    logic        w_pc_en;
    logic        w_mem_write;
    logic        w_ir_write;
    logic        w_reg_write;
    logic        w_retire;

    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        w_retire  = 1'b0;
        w_pc_en     = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        IorD      = 1'b0;
        memRead   = 1'b0;
        regDst    = 1'b0;
        memToReg  = 1'b0;
        aluSrcA   = 1'b0;
        aluSrcB   = 2'b00;
        pcSource  = 2'b00;
        inputULA  = c_alu_add;

        case (state_q)
            S_FETCH: begin
                memRead    = 1'b1;
                w_ir_write = 1'b1;
                w_pc_en    = 1'b1;
                aluSrcB    = 2'b01;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                // ALU precomputes the branch target while decoding.
                aluSrcB = 2'b11;
                case (opcode)
                    c_op_rtype:      state_d = S_RTEXE;
                    c_op_lw, c_op_sw: state_d = S_MEMADR;
                    c_op_beq:        state_d = S_BRANCH;
                    c_op_j:          state_d = S_JUMP;
                    c_op_addi:       state_d = S_ADDIEX;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                state_d = (opcode == c_op_lw) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                memRead = 1'b1;
                IorD    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                w_reg_write = 1'b1;
                memToReg    = 1'b1;
                w_retire    = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWR: begin
                w_mem_write = 1'b1;
                IorD        = 1'b1;
                w_retire    = 1'b1;
                state_d     = S_FETCH;
            end
            S_RTEXE: begin
                aluSrcA = 1'b1;
                state_d = S_RTWB;
                case (funct)
                    c_fn_add: inputULA = c_alu_add;
                    c_fn_sub: inputULA = c_alu_sub;
                    c_fn_and: inputULA = c_alu_and;
                    c_fn_or:  inputULA = c_alu_or;
                    c_fn_slt: inputULA = c_alu_slt;
                    default: begin
                        // Unsupported funct: skip writeback entirely.
                        inputULA  = c_alu_add;
                        illegal_d = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_RTWB: begin
                w_reg_write = 1'b1;
                regDst      = 1'b1;
                w_retire    = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                aluSrcA  = 1'b1;
                inputULA = c_alu_sub;
                pcSource = 2'b01;
                w_pc_en  = zero;
                w_retire = 1'b1;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                w_pc_en  = 1'b1;
                pcSource = 2'b10;
                w_retire = 1'b1;
                state_d  = S_FETCH;
            end
            S_ADDIEX: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
                state_d     = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Counter wraps naturally through 32-bit modular addition.
        retired_d = w_retire ? (retired_q + 32'd1) : retired_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            retired_q <= 32'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end

    // Reset puts the FSM in FETCH, whose enables would otherwise be live;
    // gate the architecturally visible writes until reset is released.
    assign pcEn     = w_pc_en     & ~reset;
    assign memWrite = w_mem_write & ~reset;
    assign irWrite  = w_ir_write  & ~reset;
    assign regWrite = w_reg_write & ~reset;

    assign illegal  = illegal_q;
    assign retired  = retired_q;
    assign state    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Directed self-checking bench for multicycle_control.
//               Walks lw, R-type sub, beq (taken / not taken), illegal
//               opcode, j, illegal funct, addi, sw, async reset during
//               MEMWR and the retired-counter wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    logic        clk;
    logic        reset;
    logic [0:5]  opcode;
    logic [0:5]  funct;
    logic        zero;
    logic [0:3]  inputULA;
    logic        pcEn, IorD, memRead, memWrite, irWrite;
    logic        regWrite, regDst, memToReg, aluSrcA;
    logic [0:1]  aluSrcB, pcSource;
    logic        illegal;
    logic [0:31] retired;
    logic [0:3]  state;

    int checks = 0;
    int errors = 0;

    multicycle_control dut (
        .clk      (clk),
        .reset    (reset),
        .opcode   (opcode),
        .funct    (funct),
        .zero     (zero),
        .inputULA (inputULA),
        .pcEn     (pcEn),
        .IorD     (IorD),
        .memRead  (memRead),
        .memWrite (memWrite),
        .irWrite  (irWrite),
        .regWrite (regWrite),
        .regDst   (regDst),
        .memToReg (memToReg),
        .aluSrcA  (aluSrcA),
        .aluSrcB  (aluSrcB),
        .pcSource (pcSource),
        .illegal  (illegal),
        .retired  (retired),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset  = 1'b1;
        opcode = 6'b000000;
        funct  = 6'b000000;
        zero   = 1'b0;
        #12;
        // Reset state: FETCH, counters clear, writes blocked.
        chk("rst_state",    32'(state),    32'd0);
        chk("rst_retired",  retired,       32'd0);
        chk("rst_illegal",  32'(illegal),  32'd0);
        chk("rst_pcEn",     32'(pcEn),     32'd0);
        chk("rst_irWrite",  32'(irWrite),  32'd0);
        chk("rst_regWrite", 32'(regWrite), 32'd0);

        // Release reset between edges; FETCH enables become active.
        reset  = 1'b0;
        opcode = 6'b100011;          // lw
        #1;
        chk("fetch_pcEn",     32'(pcEn),     32'd1);
        chk("fetch_irWrite",  32'(irWrite),  32'd1);
        chk("fetch_memRead",  32'(memRead),  32'd1);
        chk("fetch_aluSrcB",  32'(aluSrcB),  32'd1);
        chk("fetch_inputULA", 32'(inputULA), 32'h2);

        // ---- lw: 0,1,2,3,4,0 ----
        tick();
        chk("lw_s1",        32'(state),    32'd1);
        chk("lw_dec_srcB",  32'(aluSrcB),  32'd3);
        chk("lw_dec_pcEn",  32'(pcEn),     32'd0);
        tick();
        chk("lw_s2",        32'(state),    32'd2);
        chk("lw_adr_srcA",  32'(aluSrcA),  32'd1);
        chk("lw_adr_srcB",  32'(aluSrcB),  32'd2);
        chk("lw_adr_rw",    32'(regWrite), 32'd0);
        tick();
        chk("lw_s3",        32'(state),    32'd3);
        chk("lw_rd_memRead",32'(memRead),  32'd1);
        chk("lw_rd_IorD",   32'(IorD),     32'd1);
        chk("lw_rd_rw",     32'(regWrite), 32'd0);
        tick();
        chk("lw_s4",        32'(state),    32'd4);
        chk("lw_wb_rw",     32'(regWrite), 32'd1);
        chk("lw_wb_m2r",    32'(memToReg), 32'd1);
        chk("lw_wb_dst",    32'(regDst),   32'd0);
        chk("lw_wb_ret",    retired,       32'd0);
        tick();
        chk("lw_s0",        32'(state),    32'd0);
        chk("lw_fetch_rw",  32'(regWrite), 32'd0);
        chk("lw_retired",   retired,       32'd1);

        // ---- R-type sub: 0,1,6,7 ----
        opcode = 6'b000000;
        funct  = 6'b100010;
        tick();
        chk("sub_s1",       32'(state),    32'd1);
        tick();
        chk("sub_s6",       32'(state),    32'd6);
        chk("sub_ula",      32'(inputULA), 32'h6);
        chk("sub_srcB",     32'(aluSrcB),  32'd0);
        chk("sub_srcA",     32'(aluSrcA),  32'd1);
        tick();
        chk("sub_s7",       32'(state),    32'd7);
        chk("sub_dst",      32'(regDst),   32'd1);
        chk("sub_rw",       32'(regWrite), 32'd1);
        chk("sub_m2r",      32'(memToReg), 32'd0);
        tick();
        chk("sub_s0",       32'(state),    32'd0);
        chk("sub_retired",  retired,       32'd2);

        // ---- beq taken ----
        opcode = 6'b000100;
        zero   = 1'b1;
        tick();
        tick();
        chk("beq1_s8",      32'(state),    32'd8);
        chk("beq1_pcEn",    32'(pcEn),     32'd1);
        chk("beq1_pcSrc",   32'(pcSource), 32'd1);
        chk("beq1_ula",     32'(inputULA), 32'h6);
        tick();
        chk("beq1_s0",      32'(state),    32'd0);
        chk("beq1_retired", retired,       32'd3);

        // ---- beq not taken ----
        zero = 1'b0;
        tick();
        tick();
        chk("beq0_s8",      32'(state),    32'd8);
        chk("beq0_pcEn",    32'(pcEn),     32'd0);
        tick();
        chk("beq0_retired", retired,       32'd4);

        // ---- illegal opcode ----
        opcode = 6'b111111;
        tick();
        chk("ill_s1",       32'(state),    32'd1);
        chk("ill_pulse_pre",32'(illegal),  32'd0);
        tick();
        chk("ill_s0",       32'(state),    32'd0);
        chk("ill_pulse",    32'(illegal),  32'd1);
        chk("ill_retired",  retired,       32'd4);

        // ---- j ----
        opcode = 6'b000010;
        tick();
        chk("j_s1",         32'(state),    32'd1);
        chk("ill_pulse_end",32'(illegal),  32'd0);
        tick();
        chk("j_s9",         32'(state),    32'd9);
        chk("j_pcEn",       32'(pcEn),     32'd1);
        chk("j_pcSrc",      32'(pcSource), 32'd2);
        tick();
        chk("j_retired",    retired,       32'd5);

        // ---- illegal funct ----
        opcode = 6'b000000;
        funct  = 6'b111111;
        tick();
        tick();
        chk("ifn_s6",       32'(state),    32'd6);
        chk("ifn_ula",      32'(inputULA), 32'h2);
        tick();
        chk("ifn_s0",       32'(state),    32'd0);
        chk("ifn_pulse",    32'(illegal),  32'd1);
        chk("ifn_retired",  retired,       32'd5);

        // ---- addi ----
        opcode = 6'b001000;
        tick();
        tick();
        chk("addi_s10",     32'(state),    32'd10);
        chk("addi_srcB",    32'(aluSrcB),  32'd2);
        tick();
        chk("addi_s11",     32'(state),    32'd11);
        chk("addi_rw",      32'(regWrite), 32'd1);
        chk("addi_dst",     32'(regDst),   32'd0);
        tick();
        chk("addi_retired", retired,       32'd6);

        // ---- sw complete ----
        opcode = 6'b101011;
        tick();
        tick();
        tick();
        chk("sw_s5",        32'(state),    32'd5);
        chk("sw_memWrite",  32'(memWrite), 32'd1);
        chk("sw_IorD",      32'(IorD),     32'd1);
        chk("sw_memRead",   32'(memRead),  32'd0);
        tick();
        chk("sw_retired",   retired,       32'd7);

        // ---- sw aborted by async reset in MEMWR ----
        tick();
        tick();
        tick();
        chk("swa_s5",       32'(state),    32'd5);
        #2;
        reset = 1'b1;
        #1;
        chk("swa_state",    32'(state),    32'd0);
        chk("swa_memWrite", 32'(memWrite), 32'd0);
        chk("swa_retired",  retired,       32'd0);
        chk("swa_pcEn",     32'(pcEn),     32'd0);
        tick();
        chk("swa_hold_s",   32'(state),    32'd0);
        chk("swa_hold_ir",  32'(irWrite),  32'd0);
        reset = 1'b0;
        #1;
        chk("swa_rel_pcEn", 32'(pcEn),     32'd1);

        // ---- retired wrap on j ----
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        #1;
        chk("wrap_preload", retired,       32'hFFFF_FFFF);
        opcode = 6'b000010;
        tick();
        chk("wrap_s1",      32'(state),    32'd1);
        chk("wrap_hold",    retired,       32'hFFFF_FFFF);
        tick();
        chk("wrap_s9",      32'(state),    32'd9);
        tick();
        chk("wrap_s0",      32'(state),    32'd0);
        chk("wrap_retired", retired,       32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
